// File: rtl/pw_seq_checker.sv
// pw_seq_checker: push-button password checker with a failure counter, a
// lockout period, chord rejection and a timed unlock window.
// Optional feature: define PW_TIMEOUT_EN to abandon a partial entry after
// TIMEOUT_TICKS idle cycles. Without it, a partial entry waits indefinitely.
module pw_seq_checker #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned SEQ_LEN       = 4,
    parameter logic [SEQ_LEN*$clog2(N_BTN)-1:0] CODE = {2'd3, 2'd2, 2'd1, 2'd0},
    parameter int unsigned MAX_FAIL      = 3,
    parameter int unsigned LOCK_TICKS    = 8,
    parameter int unsigned OPEN_TICKS    = 4,
    parameter int unsigned TIMEOUT_TICKS = 5
) (
    input  logic                             clkout,
    input  logic                             reset,
    input  logic [N_BTN-1:0]                 btn,
    output logic                             unlock,
    output logic                             locked,
    output logic                             fail_pulse,
    output logic [$clog2(SEQ_LEN+1)-1:0]     progress,
    output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

    localparam int unsigned IDXW = $clog2(N_BTN);
    localparam int unsigned PW   = $clog2(SEQ_LEN + 1);
    localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMAX = (OPEN_TICKS > LOCK_TICKS) ? OPEN_TICKS : LOCK_TICKS;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    // Reject parameter sets the datapath cannot represent.
    if (N_BTN < 2) begin : g_bad_n_btn
        $error("pw_seq_checker: N_BTN must be >= 2");
    end
    if (SEQ_LEN < 1) begin : g_bad_seq_len
        $error("pw_seq_checker: SEQ_LEN must be >= 1");
    end
    if (MAX_FAIL < 1) begin : g_bad_max_fail
        $error("pw_seq_checker: MAX_FAIL must be >= 1");
    end
    if (LOCK_TICKS < 1 || OPEN_TICKS < 1) begin : g_bad_ticks
        $error("pw_seq_checker: LOCK_TICKS and OPEN_TICKS must be >= 1");
    end
    if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
        $error("pw_seq_checker: TIMEOUT_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENTRY   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t            state;
    logic [N_BTN-1:0]  btn_prev;
    logic [TW-1:0]     timer;

    logic              press_evt;
    logic              press_valid;
    logic [IDXW-1:0]   press_idx;
    logic [IDXW-1:0]   code_idx;
    logic              press_match;
    logic              last_press;

    // Edge-detect a press, decode its button index and fetch the expected code digit.
    always_comb begin
        press_evt   = (btn != '0) && (btn_prev == '0);
        press_valid = $onehot(btn);
        press_idx   = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (btn[i]) press_idx = IDXW'(i);
        end
        code_idx = '0;
        for (int unsigned i = 0; i < SEQ_LEN; i++) begin
            if (progress == PW'(i)) code_idx = CODE[i*IDXW +: IDXW];
        end
        press_match = press_valid && (press_idx == code_idx);
        last_press  = (progress == PW'(SEQ_LEN - 1));
    end

`ifdef PW_TIMEOUT_EN
    localparam int unsigned TOW = $clog2(TIMEOUT_TICKS + 1);
    logic [TOW-1:0] tmo_cnt;
`endif

    // Sequence FSM with registered outputs, open/lock timer and failure counter.
    always_ff @(posedge clkout or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            btn_prev   <= '0;
            timer      <= '0;
            unlock     <= 1'b0;
            locked     <= 1'b0;
            fail_pulse <= 1'b0;
            progress   <= '0;
            fail_cnt   <= '0;
`ifdef PW_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            btn_prev   <= btn;
            fail_pulse <= 1'b0;
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (press_evt) begin
`ifdef PW_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (press_match) begin
                            if (last_press) begin
                                state    <= S_OPEN;
                                unlock   <= 1'b1;
                                progress <= '0;
                                fail_cnt <= '0;
                                timer    <= TW'(OPEN_TICKS - 1);
                            end else begin
                                state    <= S_ENTRY;
                                progress <= progress + 1'b1;
                            end
                        end else begin
                            // Wrong digit or chord: count it, lock out when the limit is hit.
                            fail_pulse <= 1'b1;
                            progress   <= '0;
                            if (fail_cnt >= FW'(MAX_FAIL - 1)) begin
                                state    <= S_LOCKOUT;
                                locked   <= 1'b1;
                                fail_cnt <= FW'(MAX_FAIL);
                                timer    <= TW'(LOCK_TICKS - 1);
                            end else begin
                                state    <= S_IDLE;
                                fail_cnt <= fail_cnt + 1'b1;
                            end
                        end
                    end
`ifdef PW_TIMEOUT_EN
                    else if (state == S_ENTRY) begin
                        // Abandon a stalled partial entry without counting a failure.
                        if (tmo_cnt == TOW'(TIMEOUT_TICKS - 1)) begin
                            state    <= S_IDLE;
                            progress <= '0;
                            tmo_cnt  <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
`endif
                end
                S_OPEN: begin
                    if (timer == '0) begin
                        state  <= S_IDLE;
                        unlock <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        state    <= S_IDLE;
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pw_seq_checker.sv
// Self-checking bench for pw_seq_checker with default parameters, using a
// counter-based reference model of the lock behaviour.
`timescale 1ns/1ps
module tb_pw_seq_checker;

    localparam int SEQ_LEN       = 4;
    localparam int MAX_FAIL      = 3;
    localparam int LOCK_TICKS    = 8;
    localparam int OPEN_TICKS    = 4;
    localparam int TIMEOUT_TICKS = 5;

    logic       clkout = 1'b0;
    logic       reset  = 1'b0;
    logic [3:0] btn    = '0;
    logic       unlock, locked, fail_pulse;
    logic [2:0] progress;
    logic [1:0] fail_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected outputs after each edge.
    int   code_digit [SEQ_LEN] = '{0, 1, 2, 3};
    int   m_prog, m_fails, m_open_left, m_lock_left, m_idle;
    bit   m_fp;
    logic [3:0] m_prev;

    pw_seq_checker dut (
        .clkout     (clkout),
        .reset      (reset),
        .btn        (btn),
        .unlock     (unlock),
        .locked     (locked),
        .fail_pulse (fail_pulse),
        .progress   (progress),
        .fail_cnt   (fail_cnt)
    );

    always #5 clkout = ~clkout;

    task automatic model_reset();
        m_prog = 0; m_fails = 0; m_open_left = 0; m_lock_left = 0;
        m_idle = 0; m_fp = 0; m_prev = '0;
    endtask

    task automatic model_step(input logic [3:0] b);
        bit ev;
        ev   = (b != 0) && (m_prev == 0);
        m_fp = 0;
        if (m_open_left > 0) begin
            m_open_left--;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (ev) begin
            m_idle = 0;
            if ($countones(b) == 1 && b == (4'b0001 << code_digit[m_prog])) begin
                if (m_prog == SEQ_LEN - 1) begin
                    m_prog = 0; m_fails = 0; m_open_left = OPEN_TICKS;
                end else begin
                    m_prog++;
                end
            end else begin
                m_fp = 1; m_prog = 0; m_fails++;
                if (m_fails >= MAX_FAIL) begin
                    m_fails = MAX_FAIL; m_lock_left = LOCK_TICKS;
                end
            end
        end else if (m_prog > 0) begin
`ifdef PW_TIMEOUT_EN
            m_idle++;
            if (m_idle == TIMEOUT_TICKS) begin
                m_prog = 0; m_idle = 0;
            end
`endif
        end
        m_prev = b;
    endtask

    function automatic logic [7:0] exp_vec();
        return {m_open_left > 0, m_lock_left > 0, m_fp, 3'(m_prog), 2'(m_fails)};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {unlock, locked, fail_pulse, progress, fail_cnt};
    endfunction

    // Drive btn mid-cycle, clock it in, advance the model, settle for sampling.
    task automatic step(input logic [3:0] b);
        @(negedge clkout);
        btn = b;
        @(posedge clkout);
        model_step(b);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clkout);
        btn   = '0;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== 8'h00) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", dut_vec(), 8'h00);
        end
        @(negedge clkout);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(4'h0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_correct_seq();
        logic [3:0] seq[$] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0,
                                4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        int ucnt = 0;
        do_reset();
        foreach (seq[i]) begin
            step(seq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL correct_seq cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
            end
            if (i == 4) begin
                checks++;
                if (progress !== 3'd3) begin
                    failures++;
                    $display("FAIL correct_seq_progress got=%0d exp=3", progress);
                end
            end
            if (unlock) ucnt++;
        end
        checks++;
        if (ucnt != OPEN_TICKS || fail_cnt !== 2'd0) begin
            failures++;
            $display("FAIL correct_seq_unlock_len got=%0d/%0d exp=%0d/0", ucnt, fail_cnt, OPEN_TICKS);
        end
    endtask

    task automatic test_wrong_then_right();
        logic [3:0] seq[$] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0,
                                4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0};
        int fpcnt = 0;
        do_reset();
        foreach (seq[i]) begin
            step(seq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL wrong_then_right cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
            end
            if (fail_pulse) fpcnt++;
            if (i == 4) begin
                checks++;
                if (fail_pulse !== 1'b1 || progress !== 3'd0 || fail_cnt !== 2'd1) begin
                    failures++;
                    $display("FAIL wrong_press got=%b/%0d/%0d exp=1/0/1", fail_pulse, progress, fail_cnt);
                end
            end
            if (i == 12) begin
                checks++;
                if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin
                    failures++;
                    $display("FAIL retry_unlock got=%b/%0d exp=1/0", unlock, fail_cnt);
                end
            end
        end
        checks++;
        if (fpcnt != 1) begin
            failures++;
            $display("FAIL fail_pulse_width got=%0d exp=1", fpcnt);
        end
    endtask

    task automatic test_lockout();
        logic [3:0] seq[$] = '{4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0,
                                4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
        int lcnt = 0;
        do_reset();
        foreach (seq[i]) begin
            step(seq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL lockout cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
            end
            if (locked) begin
                lcnt++;
                checks++;
                if (progress !== 3'd0 || unlock !== 1'b0) begin
                    failures++;
                    $display("FAIL lockout_ignores cyc=%0d got=%0d/%b exp=0/0", i, progress, unlock);
                end
            end
        end
        checks++;
        if (lcnt != LOCK_TICKS || fail_cnt !== 2'd0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL lockout_len got=%0d/%0d exp=%0d/0", lcnt, fail_cnt, LOCK_TICKS);
        end
    endtask

    task automatic test_chord_hold();
        do_reset();
        step(4'h3);
        checks++;
        if (fail_pulse !== 1'b1 || fail_cnt !== 2'd1 || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL chord got=%b exp=%b", dut_vec(), exp_vec());
        end
        step(4'h0);
        do_reset();
        for (int i = 0; i < 6; i++) step(4'h1);
        checks++;
        if (progress !== 3'd1 || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL hold got=%b exp=%b", dut_vec(), exp_vec());
        end
        step(4'h3);
        checks++;
        if (progress !== 3'd1 || fail_cnt !== 2'd0 || fail_pulse !== 1'b0) begin
            failures++;
            $display("FAIL no_release_change got=%0d/%0d/%b exp=1/0/0", progress, fail_cnt, fail_pulse);
        end
        step(4'h0);
    endtask

    task automatic test_timeout();
        do_reset();
        step(4'h1);
        for (int i = 0; i < 20; i++) begin
            step(4'h0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL timeout cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
            end
`ifdef PW_TIMEOUT_EN
            if (i == TIMEOUT_TICKS - 1) begin
                checks++;
                if (progress !== 3'd0 || fail_cnt !== 2'd0) begin
                    failures++;
                    $display("FAIL timeout_expire got=%0d/%0d exp=0/0", progress, fail_cnt);
                end
            end
`endif
        end
`ifndef PW_TIMEOUT_EN
        checks++;
        if (progress !== 3'd1) begin
            failures++;
            $display("FAIL no_timeout got=%0d exp=1", progress);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq[$] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0};
        do_reset();
        step(4'h1); step(4'h0); step(4'h2);
        do_reset();
        for (int i = 0; i < 3; i++) begin step(4'h8); step(4'h0); end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL reach_lockout got=%b exp=1", locked);
        end
        do_reset();
        foreach (seq[i]) begin
            step(seq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL after_reset cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] b;
        int r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      b = 4'h0;
            else if (r < 75) b = 4'b0001 << code_digit[m_prog];
            else if (r < 92) b = 4'b0001 << $urandom_range(0, 3);
            else             b = 4'($urandom_range(1, 15));
            step(b);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d btn=%b got=%b exp=%b", i, b, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_correct_seq();
        test_wrong_then_right();
        test_lockout();
        test_chord_hold();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
